// File: rtl/asym_ram_pkg.sv
// Shared types and width helpers for the asymmetric dual-port RAM with clear engine.
package asym_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int mask_width(input int dataWidthA);
    return dataWidthA / 8;
  endfunction

  function automatic int data_width_b(input int dataWidthA, input int ratio);
    return dataWidthA * ratio;
  endfunction

  function automatic int addr_width_b(input int addrWidthA, input int ratio);
    return addrWidthA - clog2(ratio);
  endfunction

  function automatic bit params_legal(input int dataWidthA, input int ratio);
    return ((ratio == 1) || (ratio == 2) || (ratio == 4)) && ((dataWidthA % 8) == 0);
  endfunction

endpackage

// File: rtl/dual_port_ram_core.sv
// Inferred single-clock RAM: one byte-enabled write port, two registered read ports.
module dual_port_ram_core #(
  parameter  int ADDR_WIDTH = 12,
  parameter  int DATA_WIDTH = 32,
  localparam int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTES-1:0]      i_wrBe,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_rdEnA,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrA,
  output logic [DATA_WIDTH-1:0] o_rdDataA,
  input  logic                  i_rdEnB,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrB,
  output logic [DATA_WIDTH-1:0] o_rdDataB
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdDataA;
  logic [DATA_WIDTH-1:0] r_rdDataB;

  always_ff @(posedge clock) begin
    for (int j = 0; j < BYTES; j++) begin
      if (i_wrBe[j]) r_mem[i_wrAddr][8*j +: 8] <= i_wrData[8*j +: 8];
    end
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rdDataA <= '0;
      r_rdDataB <= '0;
    end else begin
      if (i_rdEnA) r_rdDataA <= r_mem[i_rdAddrA];
      if (i_rdEnB) r_rdDataB <= r_mem[i_rdAddrB];
    end
  end

  assign o_rdDataA = r_rdDataA;
  assign o_rdDataB = r_rdDataB;

endmodule

// File: rtl/asym_dual_port_ram_clr.sv
// Narrow R/W port A, wide read port B, hardware clear engine and A->B write forwarding.
module asym_dual_port_ram_clr
  import asym_ram_pkg::*;
#(
  parameter  int ADDR_WIDTH_A   = 13,
  parameter  int DATA_WIDTH_A   = 16,
  parameter  int RATIO          = 2,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int MASK_WIDTH     = mask_width(DATA_WIDTH_A),
  localparam int DATA_WIDTH_B   = data_width_b(DATA_WIDTH_A, RATIO),
  localparam int ADDR_WIDTH_B   = addr_width_b(ADDR_WIDTH_A, RATIO)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    io_portA_rd,
  input  logic                    io_portA_wr,
  input  logic [ADDR_WIDTH_A-1:0] io_portA_addr,
  input  logic [MASK_WIDTH-1:0]   io_portA_mask,
  input  logic [DATA_WIDTH_A-1:0] io_portA_din,
  output logic [DATA_WIDTH_A-1:0] io_portA_dout,
  output logic                    io_portA_valid,
  input  logic                    io_portB_rd,
  input  logic [ADDR_WIDTH_B-1:0] io_portB_addr,
  output logic [DATA_WIDTH_B-1:0] io_portB_dout,
  output logic                    io_portB_valid
);

  localparam int LOG2R      = clog2(RATIO);
  localparam int LANE_BITS  = (LOG2R > 0) ? LOG2R : 1;
  localparam int WIDE_BYTES = MASK_WIDTH * RATIO;

  if (!params_legal(DATA_WIDTH_A, RATIO)) begin : g_badParams
    $error("asym_dual_port_ram_clr: RATIO must be 1, 2 or 4 and DATA_WIDTH_A a multiple of 8");
  end

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_clrPending;
  logic [ADDR_WIDTH_B-1:0] r_clrCnt;

  logic                    w_idle;
  logic                    w_aRd;
  logic                    w_aWr;
  logic                    w_bRd;
  logic [ADDR_WIDTH_B-1:0] w_aWideAddr;
  logic [LANE_BITS-1:0]    w_aLane;
  logic [WIDE_BYTES-1:0]   w_aBe;
  logic [DATA_WIDTH_B-1:0] w_aBits;
  logic [DATA_WIDTH_B-1:0] w_aWideData;

  logic [WIDE_BYTES-1:0]   w_wrBe;
  logic [ADDR_WIDTH_B-1:0] w_wrAddr;
  logic [DATA_WIDTH_B-1:0] w_wrData;
  logic [DATA_WIDTH_B-1:0] w_rdDataA;
  logic [DATA_WIDTH_B-1:0] w_rdDataB;

  logic                    r_validA;
  logic                    r_validB;
  logic [LANE_BITS-1:0]    r_laneA;
  logic [DATA_WIDTH_B-1:0] r_fwdBits;
  logic [DATA_WIDTH_B-1:0] r_fwdData;

  assign w_idle      = (r_state == IDLE);
  assign w_aRd       = io_portA_rd & w_idle;
  assign w_aWr       = io_portA_wr & w_idle;
  assign w_bRd       = io_portB_rd & w_idle;
  assign w_aWideAddr = ADDR_WIDTH_B'(io_portA_addr >> LOG2R);
  assign w_aLane     = LANE_BITS'(io_portA_addr % RATIO);
  assign w_aBe       = WIDE_BYTES'(io_portA_mask) << (w_aLane * MASK_WIDTH);
  assign w_aWideData = {RATIO{io_portA_din}};
  assign busy        = (r_state == CLEAR);

  always_comb begin
    w_aBits = '0;
    for (int j = 0; j < WIDE_BYTES; j++) begin
      w_aBits[8*j +: 8] = {8{w_aBe[j]}};
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (clear_req || r_clrPending) w_nextState = CLEAR;
      CLEAR:   if (r_clrCnt == '1) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Reset parks the FSM in IDLE with a pending flag so busy stays low until release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_clrPending <= (CLEAR_ON_RESET != 0);
      r_clrCnt     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == CLEAR) r_clrPending <= 1'b0;
      r_clrCnt <= (r_state == CLEAR) ? r_clrCnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_wrBe   = '0;
    w_wrAddr = w_aWideAddr;
    w_wrData = w_aWideData;
    if (r_state == CLEAR) begin
      w_wrBe   = '1;
      w_wrAddr = r_clrCnt;
      w_wrData = '0;
    end else if (w_aWr) begin
      w_wrBe = w_aBe;
    end
  end

  dual_port_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH_B),
    .DATA_WIDTH (DATA_WIDTH_B)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .i_wrBe    (w_wrBe),
    .i_wrAddr  (w_wrAddr),
    .i_wrData  (w_wrData),
    .i_rdEnA   (w_aRd),
    .i_rdAddrA (w_aWideAddr),
    .o_rdDataA (w_rdDataA),
    .i_rdEnB   (w_bRd),
    .i_rdAddrB (io_portB_addr),
    .o_rdDataB (w_rdDataB)
  );

  // A write landing on the word B is reading is remembered and merged over the stale RAM data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_validA  <= 1'b0;
      r_validB  <= 1'b0;
      r_laneA   <= '0;
      r_fwdBits <= '0;
      r_fwdData <= '0;
    end else begin
      r_validA <= w_aRd;
      r_validB <= w_bRd;
      if (w_aRd) r_laneA <= w_aLane;
      if (w_bRd) begin
        r_fwdBits <= (w_aWr && (w_aWideAddr == io_portB_addr)) ? w_aBits : '0;
        r_fwdData <= w_aWideData;
      end
    end
  end

  always_comb begin
    io_portA_dout = w_rdDataA[DATA_WIDTH_A-1:0];
    for (int i = 1; i < RATIO; i++) begin
      if (r_laneA == LANE_BITS'(i)) io_portA_dout = w_rdDataA[i*DATA_WIDTH_A +: DATA_WIDTH_A];
    end
  end

  assign io_portB_dout  = (w_rdDataB & ~r_fwdBits) | (r_fwdData & r_fwdBits);
  assign io_portA_valid = r_validA;
  assign io_portB_valid = r_validB;

endmodule
